// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: sequences one Tetris turn (generate, fall/move, land, clear)
// through start/done handshakes with the datapath units. Also owns the gravity
// timer, level progression, cleared-line count and a pause mode.
module game_ctrl_fsm #(
  parameter int TICK_W          = 20,
  parameter int BASE_PERIOD     = 500000,
  parameter int LEVEL_W         = 4,
  parameter int LINES_PER_LEVEL = 10,
  parameter int ROWS            = 20
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               start,
  input  logic               new_game,
  input  logic               pause_req,
  input  logic               gen_done,
  input  logic               game_over,
  input  logic               touched,
  input  logic               land_done,
  input  logic [ROWS-1:0]    full_rows,
  input  logic               clear_done,
  output logic [2:0]         state,
  output logic               start_gen,
  output logic               start_land,
  output logic               start_clear,
  output logic               move_en,
  output logic               drop_tick,
  output logic [ROWS-1:0]    clear_mask,
  output logic [LEVEL_W-1:0] level,
  output logic [15:0]        lines_total,
  output logic               paused
);

  typedef enum logic [2:0] {
    NEWBOARD = 3'd0,
    GEN      = 3'd1,
    MOVE     = 3'd2,
    LAND     = 3'd3,
    CLEAR    = 3'd4,
    GAMEOVER = 3'd5,
    PAUSE    = 3'd6
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [TICK_W-1:0]   cnt_q;
  logic [TICK_W-1:0]   cnt_d;
  logic [TICK_W-1:0]   period_m1;
  logic [15:0]         lines_in_level_q;
  logic [15:0]         rows_n;
  logic [15:0]         level_sum;
  logic                drop_tick_d;
  logic                board_reset;
  logic                clear_latch;

  // Number of completed rows in a mask.
  function automatic logic [15:0] popcount(input logic [ROWS-1:0] m);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < ROWS; i++) c = c + 16'(m[i]);
    return c;
  endfunction

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Gravity period halves per level and never drops below one clock.
  function automatic logic [TICK_W-1:0] gravity_period(input logic [LEVEL_W-1:0] lvl);
    logic [31:0] p;
    p = 32'(BASE_PERIOD) >> lvl;
    if (p == 32'd0) p = 32'd1;
    return p[TICK_W-1:0];
  endfunction

  assign state       = state_q;
  assign period_m1   = gravity_period(level) - TICK_W'(1);
  assign rows_n      = popcount(full_rows);
  assign level_sum   = sat_add16(lines_in_level_q, rows_n);
  assign board_reset = (state_q == NEWBOARD) && (state_d == GEN);
  assign clear_latch = (state_q == LAND) && (state_d == CLEAR);

  // Next-state selection; new_game overrides everything outside NEWBOARD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NEWBOARD: if (start)      state_d = GEN;
      GEN:      if (gen_done)   state_d = game_over ? GAMEOVER : MOVE;
      MOVE: begin
        if (touched)            state_d = LAND;
        else if (pause_req)     state_d = PAUSE;
      end
      PAUSE:    if (pause_req)  state_d = MOVE;
      LAND:     if (land_done)  state_d = (|full_rows) ? CLEAR : GEN;
      CLEAR:    if (clear_done) state_d = GEN;
      GAMEOVER: state_d = GAMEOVER;
      default:  state_d = NEWBOARD;
    endcase
    if (new_game && (state_q != NEWBOARD)) state_d = NEWBOARD;
  end

  // Gravity counter: restarts on entry from GEN, runs in MOVE, freezes elsewhere.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == GEN) && (state_d == MOVE)) begin
      cnt_d = '0;
    end else if (state_q == MOVE) begin
      cnt_d = (cnt_q == period_m1) ? '0 : cnt_q + TICK_W'(1);
    end
    drop_tick_d = (state_d == MOVE) && (cnt_d == period_m1);
  end

  // State register and registered state-decoded outputs.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q     <= NEWBOARD;
      start_gen   <= 1'b0;
      start_land  <= 1'b0;
      start_clear <= 1'b0;
      move_en     <= 1'b0;
      paused      <= 1'b0;
      drop_tick   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_gen   <= (state_d == GEN)   && (state_q != GEN);
      start_land  <= (state_d == LAND)  && (state_q != LAND);
      start_clear <= (state_d == CLEAR) && (state_q != CLEAR);
      move_en     <= (state_d == MOVE);
      paused      <= (state_d == PAUSE);
      drop_tick   <= drop_tick_d;
      cnt_q       <= cnt_d;
    end
  end

  // Line bookkeeping: cleared at game start, updated when rows are latched for clearing.
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      clear_mask       <= '0;
      level            <= '0;
      lines_total      <= '0;
      lines_in_level_q <= '0;
    end else if (board_reset) begin
      level            <= '0;
      lines_total      <= '0;
      lines_in_level_q <= '0;
    end else if (clear_latch) begin
      clear_mask  <= full_rows;
      lines_total <= sat_add16(lines_total, rows_n);
      if (level_sum >= 16'(LINES_PER_LEVEL)) begin
        lines_in_level_q <= level_sum - 16'(LINES_PER_LEVEL);
        if (level != '1) level <= level + LEVEL_W'(1);
      end else begin
        lines_in_level_q <= level_sum;
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm: directed test-plan sequence followed by random
// stimulus, every cycle scored against a turn-level reference model.
module tb_game_ctrl_fsm;

  localparam int ROWS = 8;
  localparam int S_NB = 0, S_GEN = 1, S_MOVE = 2, S_LAND = 3, S_CLEAR = 4, S_GO = 5, S_PAUSE = 6;

  logic clk = 1'b0;
  logic restart_n, start, new_game, pause_req, gen_done, game_over;
  logic touched, land_done, clear_done;
  logic [ROWS-1:0] full_rows;
  logic [2:0] st;
  logic sg, sl, sc, me, dt, pa;
  logic [ROWS-1:0] mask;
  logic [3:0] lvl;
  logic [15:0] lines;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [2:0]  st;
    logic        sg, sl, sc, me, dt, pa;
    logic [7:0]  mask;
    logic [3:0]  lvl;
    logic [15:0] lines;
  } exp_t;
  exp_t sb[$];

  // reference model state
  int m_st, m_k, m_level, m_lines, m_lil;
  logic [7:0] m_mask;

  game_ctrl_fsm #(.TICK_W(4), .BASE_PERIOD(8), .LEVEL_W(4), .LINES_PER_LEVEL(4), .ROWS(ROWS)) dut (
    .clka(clk), .restart_n(restart_n), .start(start), .new_game(new_game),
    .pause_req(pause_req), .gen_done(gen_done), .game_over(game_over),
    .touched(touched), .land_done(land_done), .full_rows(full_rows),
    .clear_done(clear_done), .state(st), .start_gen(sg), .start_land(sl),
    .start_clear(sc), .move_en(me), .drop_tick(dt), .clear_mask(mask),
    .level(lvl), .lines_total(lines), .paused(pa)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_st = S_NB; m_k = 0; m_level = 0; m_lines = 0; m_lil = 0; m_mask = '0;
  endtask

  // One clock of the game rules applied to the current inputs; pushes expected outputs.
  task automatic model_step();
    exp_t e;
    int nxt, per, n, s;
    if (!restart_n) begin
      model_reset();
      e = '{st:3'd0, sg:0, sl:0, sc:0, me:0, dt:0, pa:0, mask:8'h0, lvl:4'h0, lines:16'h0};
      sb.push_back(e);
      return;
    end
    nxt = m_st;
    if (m_st != S_NB && new_game) nxt = S_NB;
    else begin
      case (m_st)
        S_NB:    if (start) nxt = S_GEN;
        S_GEN:   if (gen_done) nxt = game_over ? S_GO : S_MOVE;
        S_MOVE:  if (touched) nxt = S_LAND; else if (pause_req) nxt = S_PAUSE;
        S_PAUSE: if (pause_req) nxt = S_MOVE;
        S_LAND:  if (land_done) nxt = (full_rows != 0) ? S_CLEAR : S_GEN;
        S_CLEAR: if (clear_done) nxt = S_GEN;
        default: nxt = m_st;
      endcase
    end
    if (m_st == S_NB && nxt == S_GEN) begin
      m_level = 0; m_lines = 0; m_lil = 0;
    end
    if (m_st == S_LAND && nxt == S_CLEAR) begin
      n = $countones(full_rows);
      m_mask = full_rows;
      m_lines = (m_lines + n > 65535) ? 65535 : m_lines + n;
      s = m_lil + n;
      if (s >= 4) begin
        m_lil = s - 4;
        if (m_level < 15) m_level++;
      end else m_lil = s;
    end
    // m_k is the 1-based index of the upcoming MOVE cycle within this fall
    if (nxt == S_MOVE) m_k = (m_st == S_GEN) ? 1 : m_k + 1;
    per = 8 >> m_level;
    if (per == 0) per = 1;
    e.st    = 3'(nxt);
    e.sg    = (nxt == S_GEN)   && (m_st != S_GEN);
    e.sl    = (nxt == S_LAND)  && (m_st != S_LAND);
    e.sc    = (nxt == S_CLEAR) && (m_st != S_CLEAR);
    e.me    = (nxt == S_MOVE);
    e.pa    = (nxt == S_PAUSE);
    e.dt    = (nxt == S_MOVE) && (m_k % per == 0);
    e.mask  = m_mask;
    e.lvl   = 4'(m_level);
    e.lines = 16'(m_lines);
    m_st = nxt;
    sb.push_back(e);
  endtask

  // Apply current inputs for one clock, then drop the single-cycle inputs.
  task automatic tick();
    model_step();
    @(negedge clk);
    start = 0; new_game = 0; pause_req = 0; gen_done = 0; game_over = 0;
    touched = 0; land_done = 0; clear_done = 0; full_rows = '0;
  endtask

  // Monitor: after each edge, compare the DUT against the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("mon.state", 32'(st), 32'(e.st));
        chk("mon.start_gen", 32'(sg), 32'(e.sg));
        chk("mon.start_land", 32'(sl), 32'(e.sl));
        chk("mon.start_clear", 32'(sc), 32'(e.sc));
        chk("mon.move_en", 32'(me), 32'(e.me));
        chk("mon.drop_tick", 32'(dt), 32'(e.dt));
        chk("mon.paused", 32'(pa), 32'(e.pa));
        chk("mon.clear_mask", 32'(mask), 32'(e.mask));
        chk("mon.level", 32'(lvl), 32'(e.lvl));
        chk("mon.lines_total", 32'(lines), 32'(e.lines));
      end
    end
  end

  initial begin
    int ticks, bad, first;
    restart_n = 0; start = 0; new_game = 0; pause_req = 0; gen_done = 0; game_over = 0;
    touched = 0; land_done = 0; clear_done = 0; full_rows = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.state", 32'(st), 0);
    chk("rst.pulses", 32'({sg, sl, sc, me, dt, pa}), 0);
    chk("rst.mask", 32'(mask), 0);
    chk("rst.level", 32'(lvl), 0);
    chk("rst.lines", 32'(lines), 0);
    restart_n = 1;

    // start a game
    start = 1; tick();
    chk("dir.start_state", 32'(st), 1);
    chk("dir.start_gen_hi", 32'(sg), 1);
    tick();
    chk("dir.start_gen_lo", 32'(sg), 0);

    // level 0 gravity: 3 ticks in 24 MOVE cycles
    gen_done = 1; tick();
    ticks = 0; bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (dt) ticks++;
      if (!me) bad++;
      tick();
    end
    chk("dir.ticks24", 32'(ticks), 3);
    chk("dir.move_en24", 32'(bad), 0);

    // pause at count 5, hold, resume
    repeat (5) tick();
    pause_req = 1; tick();
    chk("dir.paused", 32'(pa), 1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      if (dt) ticks++;
      tick();
    end
    chk("dir.pause_noticks", 32'(ticks), 0);
    pause_req = 1; tick();
    first = -1;
    for (int i = 0; i < 4; i++) begin
      if (dt && first < 0) first = i;
      tick();
    end
    chk("dir.resume_first_tick", 32'(first), 1);

    // land four rows: level 1, lines 4
    touched = 1; tick();
    chk("dir.land_state", 32'(st), 3);
    chk("dir.start_land", 32'(sl), 1);
    land_done = 1; full_rows = 8'h0F; tick();
    chk("dir.clear_state", 32'(st), 4);
    chk("dir.clear_mask", 32'(mask), 32'h0F);
    chk("dir.lines4", 32'(lines), 4);
    chk("dir.level1", 32'(lvl), 1);
    chk("dir.start_clear", 32'(sc), 1);
    clear_done = 1; tick();
    chk("dir.regen_pulse", 32'(sg), 1);
    gen_done = 1; tick();
    ticks = 0; first = -1;
    for (int i = 0; i < 8; i++) begin
      if (dt) begin ticks++; if (first < 0) first = i; end
      tick();
    end
    chk("dir.l1_ticks", 32'(ticks), 2);
    chk("dir.l1_first", 32'(first), 3);

    // game over, start ignored, new_game recovers, counters cleared
    touched = 1; tick();
    land_done = 1; full_rows = 8'h00; tick();
    chk("dir.noclear_gen", 32'(st), 1);
    gen_done = 1; game_over = 1; tick();
    chk("dir.gameover", 32'(st), 5);
    start = 1; tick();
    chk("dir.gameover_hold", 32'(st), 5);
    new_game = 1; tick();
    chk("dir.newgame", 32'(st), 0);
    start = 1; tick();
    chk("dir.restart_level", 32'(lvl), 0);
    chk("dir.restart_lines", 32'(lines), 0);

    // touched beats pause_req
    gen_done = 1; tick();
    touched = 1; pause_req = 1; tick();
    chk("dir.touch_wins", 32'(st), 3);
    chk("dir.touch_nopause", 32'(pa), 0);
    land_done = 1; full_rows = 8'h81; tick();
    tick();
    chk("dir.midclear", 32'(st), 4);

    // asynchronous reset in the middle of CLEAR
    restart_n = 0;
    #1;
    chk("dir.arst_state", 32'(st), 0);
    chk("dir.arst_outs", 32'({sg, sl, sc, me, dt, pa}), 0);
    chk("dir.arst_data", 32'({mask, lvl, lines}), 0);
    tick();
    restart_n = 1;

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      restart_n  = ($urandom_range(0, 499) != 0);
      start      = ($urandom_range(0, 9) < 3);
      new_game   = ($urandom_range(0, 99) < 4);
      pause_req  = ($urandom_range(0, 9) == 0);
      gen_done   = ($urandom_range(0, 9) < 4);
      game_over  = ($urandom_range(0, 9) == 0);
      touched    = ($urandom_range(0, 99) < 12);
      land_done  = ($urandom_range(0, 9) < 4);
      full_rows  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      clear_done = ($urandom_range(0, 9) < 4);
      tick();
      restart_n = 1;
    end
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
